// File: rtl/sram_ctrl_if.sv
// Request/response bus between a requester and sram_ctrl.
// Write data carries one even-parity bit per byte lane above the data bits.
interface sram_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();
  localparam int unsigned LANES = DATA_W / 8;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [31:0]             req_addr;
  logic [DATA_W+LANES-1:0] req_wdata;
  logic [LANES-1:0]        req_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller with per-byte parity, address window decode
// and a sticky parity-error flag; one request in flight at a time.
module sram_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned SIZE_BYTES = 32768,
  parameter int unsigned DATA_W     = 32
) (
  input  logic        clock,
  input  logic        reset,
  sram_ctrl_if.slave  bus,
  output logic        parity_error_flag,
  input  logic        parity_clear
);
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned WORDS = SIZE_BYTES / LANES;
  localparam int unsigned OFF_W = $clog2(SIZE_BYTES);
  localparam int unsigned LSB   = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_W+LANES-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    perr_q, perr_d;

  logic [DATA_W-1:0]       mem_data [WORDS];
  logic [LANES-1:0]        mem_par  [WORDS];

  logic [31:0]             offset;
  logic                    hit;
  logic [OFF_W-LSB-1:0]    widx;
  logic [DATA_W-1:0]       rd_word;
  logic [LANES-1:0]        rd_par;
  logic                    wpar_bad;
  logic                    rpar_bad;
  logic                    perr_set;
  logic                    mem_we;

  // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    hit      = (offset < SIZE_BYTES) && ((addr_q & 32'(LANES - 1)) == '0);
    widx     = offset[OFF_W-1:LSB];
    rd_word  = mem_data[widx];
    rd_par   = mem_par[widx];
    wpar_bad = 1'b0;
    rpar_bad = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wstrb_q[i] && (wdata_q[DATA_W+i] != ^wdata_q[8*i +: 8])) wpar_bad = 1'b1;
      if (rd_par[i] != ^rd_word[8*i +: 8]) rpar_bad = 1'b1;
    end
    mem_we = (state_q == ACCESS) && write_q && hit && !wpar_bad && !reset;
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    perr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (write_q) begin
          rdata_d  = '0;
          err_d    = wpar_bad;
          perr_set = wpar_bad;
        end else begin
          rdata_d  = rd_word;
          err_d    = rpar_bad;
          perr_set = rpar_bad;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new error outranks a clear arriving on the same edge.
    perr_d = perr_set | (perr_q & ~parity_clear);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb_q[i]) begin
          mem_data[widx][8*i +: 8] <= wdata_q[8*i +: 8];
          mem_par[widx][i]         <= wdata_q[DATA_W+i];
        end
      end
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;
  assign parity_error_flag = perr_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed and randomized checks of sram_ctrl against a byte-array model.
module tb_sram_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned SIZE = 32768;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic parity_clear = 1'b0;
  logic parity_error_flag;

  sram_ctrl_if #(.DATA_W(32)) bus ();

  sram_ctrl #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .DATA_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .parity_error_flag(parity_error_flag),
    .parity_clear(parity_clear)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [7:0] mem_m [int unsigned];
  logic exp_flag = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] par_of(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({tag, ".rsp_err"},   64'(bus.rsp_err),   64'd0);
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] flip, input int hold,
                        input logic clr, input string tag);
    longint unsigned a, off;
    logic hit, known, pbad, exp_err;
    logic [31:0] exp_rd;
    int cnt;
    a      = longint'(addr);
    hit    = (a >= longint'(BASE)) && (a < longint'(BASE) + SIZE) && (a % 4 == 0);
    off    = a - longint'(BASE);
    pbad   = |(strb & flip);
    known  = 1'b1;
    exp_rd = '0;
    if (!hit) exp_err = 1'b1;
    else if (wr) exp_err = pbad;
    else begin
      exp_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mem_m.exists(int'(off) + i)) exp_rd[8*i +: 8] = mem_m[int'(off) + i];
        else known = 1'b0;
      end
    end

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = {par_of(data) ^ flip, data};
    bus.req_wstrb = strb;
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = {4'($urandom), $urandom};
    bus.req_wstrb = 4'($urandom);
    parity_clear  = clr;
    cnt = 1;
    while (!bus.rsp_valid && cnt < 10) begin
      @(posedge clock); #1;
      parity_clear = 1'b0;
      cnt++;
    end
    parity_clear = 1'b0;

    if (hit && wr && !pbad)
      for (int i = 0; i < 4; i++) if (strb[i]) mem_m[int'(off) + i] = data[8*i +: 8];
    if (hit && wr && pbad) exp_flag = 1'b1;
    else if (clr) exp_flag = 1'b0;

    chk({tag, ".latency"}, 64'(cnt), 64'd2);
    chk({tag, ".err"}, 64'(bus.rsp_err), 64'(exp_err));
    if (known) chk({tag, ".rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
    chk({tag, ".flag"}, 64'(parity_error_flag), 64'(exp_flag));

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = BASE;
      @(posedge clock); #1;
      chk({tag, ".hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, ".hold_err"}, 64'(bus.rsp_err), 64'(exp_err));
      if (known) chk({tag, ".hold_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
      chk({tag, ".hold_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk_idle({tag, ".after"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] addr;
    logic [3:0]  flip;
    int          sel;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk_idle("reset");
    chk("reset.flag", 64'(parity_error_flag), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    do_req(1'b1, BASE, 32'hDEAD_BEEF, 4'hF, 4'h0, 0, 1'b0, "wr_deadbeef");
    do_req(1'b0, BASE, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_deadbeef");
    chk("deadbeef.model", 64'({mem_m[3], mem_m[2], mem_m[1], mem_m[0]}), 64'h0000_0000_DEAD_BEEF);

    do_req(1'b1, BASE + 4, 32'h1122_3344, 4'hF, 4'h0, 0, 1'b0, "wr_11223344");
    do_req(1'b1, BASE + 4, 32'hAABB_CCDD, 4'h2, 4'h0, 0, 1'b0, "wr_lane1");
    do_req(1'b0, BASE + 4, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_1122cc44");
    do_req(1'b1, BASE + 4, 32'hFFFF_FFFF, 4'h0, 4'h0, 0, 1'b0, "wr_nostrb");
    do_req(1'b0, BASE + 4, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_after_nostrb");

    do_req(1'b0, BASE + 32'h8000, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_oob");
    do_req(1'b0, BASE + 2, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_misaligned");
    do_req(1'b0, BASE - 4, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_below");
    do_req(1'b1, BASE + 32'h8000, 32'h5555_5555, 4'hF, 4'h0, 0, 1'b0, "wr_oob");
    do_req(1'b0, BASE, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_unchanged");

    do_req(1'b1, BASE + SIZE - 4, 32'hCAFE_F00D, 4'hF, 4'h0, 0, 1'b0, "wr_last");
    do_req(1'b0, BASE + SIZE - 4, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_last");

    do_req(1'b1, BASE, 32'h0BAD_0BAD, 4'hF, 4'h1, 0, 1'b0, "wr_badpar");
    do_req(1'b0, BASE, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_after_badpar");
    parity_clear = 1'b1;
    @(posedge clock); #1;
    parity_clear = 1'b0;
    exp_flag = 1'b0;
    chk("clear.flag", 64'(parity_error_flag), 64'(exp_flag));

    do_req(1'b1, BASE + 8, 32'h1234_5678, 4'h4, 4'h4, 0, 1'b1, "set_vs_clear");
    parity_clear = 1'b1;
    @(posedge clock); #1;
    parity_clear = 1'b0;
    exp_flag = 1'b0;
    chk("clear2.flag", 64'(parity_error_flag), 64'(exp_flag));

    do_req(1'b0, BASE, 32'h0, 4'h0, 4'h0, 5, 1'b0, "rd_hold");
    do_req(1'b0, BASE + 4, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_after_hold");

    // Abort a write by reset while it sits in ACCESS, with the flag already set.
    do_req(1'b1, BASE, 32'h0, 4'hF, 4'h8, 0, 1'b0, "wr_setflag");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = BASE + 4;
    bus.req_wdata = {par_of(32'h9999_9999), 32'h9999_9999};
    bus.req_wstrb = 4'hF;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_idle("mid_reset");
    chk("mid_reset.flag", 64'(parity_error_flag), 64'd0);
    @(posedge clock); #1;
    chk_idle("mid_reset_edge");
    reset = 1'b0;
    exp_flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk("post_reset.no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    do_req(1'b0, BASE + 4, 32'h0, 4'h0, 4'h0, 0, 1'b0, "rd_after_abort");

    for (int w = 0; w < 8; w++)
      do_req(1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 4'h0, 0, 1'b0, "preload");

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      addr = BASE + 32'(4 * $urandom_range(0, 7));
      else if (sel == 6) addr = BASE + SIZE - 4;
      else if (sel == 7) addr = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = BASE + SIZE + 32'(4 * $urandom_range(0, 7));
      else               addr = BASE - 32'(4 * $urandom_range(1, 8));
      flip = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      do_req(1'($urandom), addr, $urandom, 4'($urandom), flip, int'($urandom_range(0, 2)),
             ($urandom_range(0, 7) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
